riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the RV32I core. It consumes the hazard unit's pcSrc/flush outputs: redirects the PC to the branch/jump target and squashes the IF/ID slot with a NOP. It drives a single-outstanding request/grant/response instruction-memory port and presents fetched instructions to decode, with stall backpressure.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) placed in IF/ID on flush or bubble

Ports:
clk  in  1  core clock; single clock domain
rst_n  in  1  reset, asynchronous assert, active-low
pcSrc  in  1  redirect request from hazard unit; next fetch PC = branchTarget
flush  in  1  squash IF/ID slot from hazard unit
branchTarget  in  32  redirect target, sampled when pcSrc=1
stall  in  1  decode backpressure; hold IF/ID contents
imem_req  out  1  fetch request
imem_addr  out  32  fetch byte address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid, at least 1 cycle after gnt
imem_rdata  in  32  instruction word
if_valid  out  1  IF/ID slot holds a real instruction
if_pc  out  32  PC of if_instr
if_pcPlus4  out  32  if_pc + 4, mod 2^32
if_instr  out  32  instruction to decode

Behaviour:
- Reset (rst_n low, async): state IDLE, pc_q=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_pcPlus4=0, if_instr=NOP_INSTR, skid buffer empty.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req=1, imem_addr=pc_q. imem_gnt -> WAIT with fetch_pc=pc_q. imem_addr changes while ungranted only on pcSrc.
- WAIT: on imem_rvalid with stall=0: if_valid=1, if_pc=fetch_pc, if_pcPlus4=fetch_pc+4, if_instr=imem_rdata, pc_q=fetch_pc+4, go REQ. On rvalid with stall=1: capture rdata in skid, go HOLD.
- HOLD: imem_req=0. When stall drops, load IF/ID from skid, pc_q=fetch_pc+4, go REQ.
- Redirect (pcSrc=1), highest priority, any state: pc_q=branchTarget with bits[1:0] forced to 0. In REQ/IDLE/HOLD: discard skid, go REQ. In WAIT without rvalid: go DRAIN. In WAIT with rvalid the same cycle: drop data, go REQ.
- DRAIN: imem_req=0. Next rvalid is discarded, then REQ.
- flush=1: next cycle if_valid=0, if_instr=NOP_INSTR, if_pc/if_pcPlus4 hold. flush overrides stall and any same-cycle load into IF/ID.
- stall=1 without flush: IF/ID outputs hold exactly.
- Best-case throughput: one instruction per 2 cycles (gnt with req, rvalid next cycle). PC increment wraps 0xFFFF_FFFC -> 0x0000_0000.
- rst_n asserted mid-transaction: the outstanding response is abandoned. Memory must drop it on reset.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: adds output if_misalign (1 bit, reset 0). A redirect with branchTarget[1:0]!=0 issues no fetch. Next cycle: if_valid=1, if_misalign=1, if_pc=branchTarget unmodified, if_instr=NOP_INSTR. State is IDLE until the next pcSrc.
- Undefined: no port; bits[1:0] are silently forced to 0.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR, RESET_PC default, fetch state enum, XLEN=32.
- One natural sub-module: riscv_if_id_reg (IF/ID register with flush/stall/load priority). The FSM and PC stay in the top module.

Test Plan:
- Reset release, memory grants immediately, rvalid next cycle, rdata 0x00500093 -> first req addr 0x0, if_valid=1 with if_pc=0x0, if_instr=0x00500093 on cycle 3; second req addr 0x4.
- stall=1 held 3 cycles while rvalid arrives with 0x00208133 -> IF/ID unchanged, imem_req=0; one cycle after stall drops if_instr=0x00208133, then req addr +4.
- pcSrc=1, flush=1, branchTarget=0x100 while in WAIT -> if_valid=0, if_instr=0x13. Pending response discarded (never reaches IF/ID). Next req addr 0x100.
- pcSrc=1 same cycle as rvalid, target 0x40 -> data dropped, next req addr 0x40 with no DRAIN cycle.
- PC at 0xFFFF_FFFC, normal fetch -> if_pcPlus4=0x0, next req addr 0x0.
- With FETCH_MISALIGN_CHECK_EN, pcSrc target 0x102 -> no imem_req. if_misalign=1, if_pc=0x102, if_instr=0x13. Then pcSrc target 0x200 resumes fetching at 0x200.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: XLEN, NOP encoding, reset PC, fetch states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- canonical bubble placed in IF/ID
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Fetch FSM encoding, kept as plain constants for compatibility with older tools
  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 3'd0;
  localparam fetch_state_t ST_REQ   = 3'd1;
  localparam fetch_state_t ST_WAIT  = 3'd2;
  localparam fetch_state_t ST_HOLD  = 3'd3;
  localparam fetch_state_t ST_DRAIN = 3'd4;

  // Sequential PC step; wraps modulo 2^32
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/riscv_if_id_reg.sv
// IF/ID pipeline register with flush > stall > load priority; empty slot reads as NOP.
// Latency: 1 cycle from load to outputs.
// Backpressure: stall freezes every output; flush overrides stall and any load.
// Ports: clk, rst_n; flush/stall controls; load + load_pc/load_instr from fetch FSM;
//        if_valid/if_pc/if_pcPlus4/if_instr to decode.
// Optional: FETCH_MISALIGN_CHECK_EN adds load_mis/mis_pc inputs and if_misalign output.
module riscv_if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
  input  logic        load_mis,
  input  logic [31:0] mis_pc,
  output logic        if_misalign,
`endif
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcPlus4,
  output logic [31:0] if_instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pcPlus4  <= '0;
      if_instr    <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
      if_misalign <= 1'b0;
`endif
    end else if (flush) begin
      // PC fields are left alone so decode/debug still see the last address
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
      if_misalign <= 1'b0;
`endif
    end else if (!stall) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (load_mis) begin
        // Trap marker: carries the raw target, no instruction was fetched
        if_valid    <= 1'b1;
        if_misalign <= 1'b1;
        if_pc       <= mis_pc;
        if_pcPlus4  <= pc_inc(mis_pc);
        if_instr    <= NOP_INSTR;
      end else
`endif
      if (load) begin
        if_valid    <= 1'b1;
        if_pc       <= load_pc;
        if_pcPlus4  <= pc_inc(load_pc);
        if_instr    <= load_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
        if_misalign <= 1'b0;
`endif
      end else begin
        // Decode consumed the slot and nothing new arrived: present a bubble
        if_valid    <= 1'b0;
        if_instr    <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
        if_misalign <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// RV32I instruction fetch: PC, single-outstanding imem req/gnt/rvalid port, IF/ID register.
// Latency: gnt with req then rvalid next cycle gives one instruction every 2 cycles.
// Backpressure: stall parks a returning word in a one-entry skid and drops imem_req until released.
// Ports: clk, rst_n; hazard inputs pcSrc/flush/branchTarget/stall; imem_req/imem_addr/imem_gnt/
//        imem_rvalid/imem_rdata memory port; if_valid/if_pc/if_pcPlus4/if_instr to decode.
// Optional: FETCH_MISALIGN_CHECK_EN adds if_misalign and reports misaligned redirect targets.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcSrc,
  input  logic        flush,
  input  logic [31:0] branchTarget,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        if_misalign,
`endif
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcPlus4,
  output logic [31:0] if_instr
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] skid, skid_nxt;
  logic [XLEN-1:0] load_instr;
  logic            load;
  logic            resp_pending;
  logic            parked;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            parked_nxt;
  logic            mis_now, mis_req, mis_pend;
  logic [XLEN-1:0] mis_pc, mis_pc_sel;

  assign mis_now    = pcSrc && (branchTarget[1:0] != 2'b00);
  // A trap marker blocked by stall is retried until a newer redirect replaces it
  assign mis_req    = mis_now || (mis_pend && !pcSrc);
  assign mis_pc_sel = mis_now ? branchTarget : mis_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parked   <= 1'b0;
      mis_pend <= 1'b0;
      mis_pc   <= '0;
    end else begin
      parked   <= parked_nxt;
      mis_pend <= mis_req && stall && !flush;
      mis_pc   <= mis_pc_sel;
    end
  end
`else
  assign parked = 1'b0;
`endif

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc_q;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    fetch_pc_nxt = fetch_pc;
    skid_nxt     = skid;
    load         = 1'b0;
    load_instr   = imem_rdata;
    resp_pending = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    parked_nxt   = parked;
`endif

    case (state)
      ST_IDLE: begin
        if (!parked) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt) begin
          fetch_pc_nxt = pc_q;
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (stall) begin
            skid_nxt  = imem_rdata;
            state_nxt = ST_HOLD;
          end else begin
            load      = 1'b1;
            pc_nxt    = pc_inc(fetch_pc);
            state_nxt = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          load       = 1'b1;
          load_instr = skid;
          pc_nxt     = pc_inc(fetch_pc);
          state_nxt  = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // Stale response from the abandoned path is swallowed here
        if (imem_rvalid) state_nxt = parked ? ST_IDLE : ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (pcSrc) begin
      load   = 1'b0;
      pc_nxt = branchTarget & ~32'd3;
      // A grant taken in this very cycle also leaves a response in flight,
      // so it must be drained just like a WAIT without rvalid.
      resp_pending = ((state == ST_REQ) && imem_gnt) ||
                     (((state == ST_WAIT) || (state == ST_DRAIN)) && !imem_rvalid);
      state_nxt = resp_pending ? ST_DRAIN : ST_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
      parked_nxt = mis_now;
      if (mis_now && !resp_pending) state_nxt = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc_q     <= RESET_PC;
      fetch_pc <= RESET_PC;
      skid     <= NOP_INSTR;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      fetch_pc <= fetch_pc_nxt;
      skid     <= skid_nxt;
    end
  end

  riscv_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .stall       (stall),
    .load        (load),
    .load_pc     (fetch_pc),
    .load_instr  (load_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
    .load_mis    (mis_req),
    .mis_pc      (mis_pc_sel),
    .if_misalign (if_misalign),
`endif
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_pcPlus4  (if_pcPlus4),
    .if_instr    (if_instr)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
`timescale 1ns/1ps
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, pcSrc, flush, stall;
  logic [31:0] branchTarget;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_pcPlus4, if_instr;
  logic        misal;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_misalign;
  assign misal = if_misalign;
`else
  assign misal = 1'b0;
`endif

  always #5 clk = ~clk;

  riscv_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcSrc        (pcSrc),
    .flush        (flush),
    .branchTarget (branchTarget),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
`ifdef FETCH_MISALIGN_CHECK_EN
    .if_misalign  (if_misalign),
`endif
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_pcPlus4   (if_pcPlus4),
    .if_instr     (if_instr)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory model: single outstanding request, response after a chosen latency
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  int          gnt_pct  = 100;
  int          lat_min  = 1;
  int          lat_max  = 1;

  // Program-order model: the next PC decode should consume
  logic [31:0] exp_pc   = 32'h0;
  int          consumed = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0020_8133;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive memory, score consumption, advance, then check stall-hold.
  task automatic cyc();
    bit          g, r;
    logic [31:0] req_a, ppc, pp4, pin;
    logic        pv, ps, pf;
    g = imem_req && !mem_busy && ($urandom_range(99) < gnt_pct);
    r = mem_busy && (mem_cnt == 0);
    imem_gnt    = g;
    imem_rvalid = r;
    imem_rdata  = r ? instr_of(mem_addr) : 32'hDEAD_BEEF;
    req_a = imem_addr;
    if (if_valid && !stall && !misal) begin
      chk("consume_pc", if_pc, exp_pc);
      chk("consume_instr", if_instr, instr_of(exp_pc));
      chk("consume_pc4", if_pcPlus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (pcSrc) exp_pc = branchTarget & 32'hFFFF_FFFC;
    pv = if_valid; ppc = if_pc; pp4 = if_pcPlus4; pin = if_instr;
    ps = stall; pf = flush;
    @(posedge clk); #1;
    if (r) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (g) begin
      mem_busy = 1'b1;
      mem_addr = req_a;
      mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    if (ps && !pf) begin
      chk("stall_hold_valid", if_valid, pv);
      chk("stall_hold_pc", if_pc, ppc);
      chk("stall_hold_pc4", if_pcPlus4, pp4);
      chk("stall_hold_instr", if_instr, pin);
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] pc);
    for (int i = 0; i < 20 && !if_valid; i++) cyc();
    chk({tag, "_valid"}, if_valid, 1);
    chk({tag, "_pc"}, if_pc, pc);
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] bt;
    int          base;
    rst_n = 1'b0; pcSrc = 1'b0; flush = 1'b0; stall = 1'b0;
    branchTarget = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pcPlus4, 32'h0);
    chk("rst_instr", if_instr, NOP);
    rst_n = 1'b1;

    // First fetch: IDLE, REQ(gnt), WAIT(rvalid), slot valid on cycle 3
    chk("idle_req", imem_req, 0);
    cyc();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    cyc();
    chk("wait_req_low", imem_req, 0);
    cyc();
    chk("first_valid", if_valid, 1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_pc4", if_pcPlus4, 32'h4);
    chk("first_instr", if_instr, 32'h0050_0093);
    chk("second_req", imem_req, 1);
    chk("second_addr", imem_addr, 32'h4);

    // Stall for 3 cycles while the response for 0x4 comes back
    cyc();
    stall = 1'b1;
    repeat (3) begin
      cyc();
      chk("stall_req_low", imem_req, 0);
    end
    stall = 1'b0;
    cyc();
    chk("skid_valid", if_valid, 1);
    chk("skid_pc", if_pc, 32'h4);
    chk("skid_instr", if_instr, 32'h0020_8133);
    chk("after_skid_req", imem_req, 1);
    chk("after_skid_addr", imem_addr, 32'h8);

    // Redirect with flush while waiting: response for 0x8 must be drained
    lat_min = 3; lat_max = 3;
    cyc();
    hold_pc = if_pc;
    pcSrc = 1'b1; flush = 1'b1; branchTarget = 32'h100;
    cyc();
    pcSrc = 1'b0; flush = 1'b0;
    chk("flush_valid", if_valid, 0);
    chk("flush_instr", if_instr, NOP);
    chk("flush_pc_hold", if_pc, hold_pc);
    chk("drain_req_low", imem_req, 0);
    lat_min = 1; lat_max = 1;
    wait_req("redir", 32'h100);
    wait_valid("redir_load", 32'h100);

    // Redirect in the same cycle as rvalid: no drain cycle
    wait_req("pre_t4", 32'h104);
    cyc();
    pcSrc = 1'b1; flush = 1'b1; branchTarget = 32'h40;
    cyc();
    pcSrc = 1'b0; flush = 1'b0;
    chk("nodrain_req", imem_req, 1);
    chk("nodrain_addr", imem_addr, 32'h40);
    chk("nodrain_valid", if_valid, 0);

    // Wrap at the top of the address space
    pcSrc = 1'b1; flush = 1'b1; branchTarget = 32'hFFFF_FFFC;
    cyc();
    pcSrc = 1'b0; flush = 1'b0;
    wait_req("wrap", 32'hFFFF_FFFC);
    cyc();
    cyc();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pcPlus4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect: trap marker, fetching parked until next redirect
    pcSrc = 1'b1; branchTarget = 32'h102;
    cyc();
    pcSrc = 1'b0;
    chk("mis_flag", if_misalign, 1);
    chk("mis_valid", if_valid, 1);
    chk("mis_pc", if_pc, 32'h102);
    chk("mis_instr", if_instr, NOP);
    repeat (6) begin
      cyc();
      chk("mis_parked_req", imem_req, 0);
    end
    pcSrc = 1'b1; flush = 1'b1; branchTarget = 32'h200;
    cyc();
    pcSrc = 1'b0; flush = 1'b0;
    wait_req("mis_resume", 32'h200);
    wait_valid("mis_resume_load", 32'h200);
`endif

    // Random traffic: variable grant/latency, random stall and redirects
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    base = consumed;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 3) begin
        bt = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_0FFC);
`ifndef FETCH_MISALIGN_CHECK_EN
        bt[1:0] = 2'($urandom_range(3));
`endif
        pcSrc = 1'b1; flush = 1'b1; branchTarget = bt;
      end else begin
        pcSrc = 1'b0; flush = 1'b0;
      end
      cyc();
    end
    pcSrc = 1'b0; flush = 1'b0; stall = 1'b0;
    repeat (10) cyc();
    chk("rand_progress", 32'(consumed - base > 30), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
